// File: rtl/mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_pipe
// Brief    : Two-stage unsigned multiply-add / frame-accumulate pipeline with
//            valid/ready handshakes and saturation of the registered result.
// Revision : 1.0
// ============================================================================
module mac_pipe #(
    parameter int input_size  = 8,
    parameter int output_size = 16,
    parameter int acc_len     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [input_size-1:0]  x,
    input  logic [input_size-1:0]  y,
    input  logic [input_size-1:0]  z,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [output_size-1:0] DATA_OUT,
    output logic                   sat
);

    localparam int c_pw = 2 * input_size;
    localparam int c_cw = $clog2(acc_len);
    localparam int c_aw = c_pw + c_cw + 1;
    localparam int c_sw = ((c_aw > output_size) ? c_aw : output_size) + 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(acc_len - 1);
    localparam logic [c_sw-1:0] c_max  = c_sw'({output_size{1'b1}});

    logic                   w_stall;
    logic                   r_s1_valid;
    logic [c_pw-1:0]        r_s1_p;
    logic [input_size-1:0]  r_s1_z;
    logic                   r_s1_mode;
    logic [c_aw-1:0]        r_acc;
    logic [c_cw-1:0]        r_count;
    logic                   r_last_mode;

    logic                   w_fresh;
    logic [c_aw-1:0]        w_acc_base;
    logic [c_cw-1:0]        w_cnt_base;
    logic [c_sw-1:0]        w_sum;
    logic                   w_frame_end;
    logic                   w_sat;
    logic [output_size-1:0] w_result;

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    // A mode switch at stage 2 drops any partial frame before this beat is used.
    always_comb begin
        w_fresh     = (r_s1_mode != r_last_mode);
        w_acc_base  = w_fresh ? '0 : r_acc;
        w_cnt_base  = w_fresh ? '0 : r_count;
        w_sum       = r_s1_mode ? (c_sw'(w_acc_base) + c_sw'(r_s1_p))
                                : (c_sw'(r_s1_p) + c_sw'(r_s1_z));
        w_frame_end = r_s1_mode && (w_cnt_base == c_last);
        w_sat       = (w_sum > c_max);
        w_result    = w_sat ? '1 : w_sum[output_size-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_p      <= '0;
            r_s1_z      <= '0;
            r_s1_mode   <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_last_mode <= 1'b0;
            out_valid   <= 1'b0;
            DATA_OUT    <= '0;
            sat         <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_p    <= c_pw'(x) * c_pw'(y);
                r_s1_z    <= z;
                r_s1_mode <= mode;
            end

            if (r_s1_valid) begin
                r_last_mode <= r_s1_mode;
                if (!r_s1_mode || w_frame_end) begin
                    out_valid <= 1'b1;
                    DATA_OUT  <= w_result;
                    sat       <= w_sat;
                    r_acc     <= '0;
                    r_count   <= '0;
                end else begin
                    out_valid <= 1'b0;
                    r_acc     <= w_sum[c_aw-1:0];
                    r_count   <= w_cnt_base + c_cw'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_pipe
// Brief    : Self-checking bench for mac_pipe (directed scenarios + random).
// Revision : 1.0
// ============================================================================
module tb_mac_pipe;

    localparam int IS = 8;
    localparam int OS = 16;
    localparam int AL = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [IS-1:0] x, y, z;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [OS-1:0] DATA_OUT;
    logic          sat;

    int checks = 0;
    int errors = 0;
    logic [OS:0] got_q[$];
    logic [OS:0] exp_q[$];

    mac_pipe #(.input_size(IS), .output_size(OS), .acc_len(AL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z(z), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .DATA_OUT(DATA_OUT), .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every transfer; the handshake completes at the following posedge.
    always @(negedge clk)
        if (rst_n && out_valid && out_ready) got_q.push_back({sat, DATA_OUT});

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic m, input logic [IS-1:0] xa, ya, za);
        int  n;
        logic a;
        mode = m; x = xa; y = ya; z = za; in_valid = 1'b1;
        n = 0; a = 1'b0;
        while (!a && n < 100) begin
            @(negedge clk);
            a = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!a) begin
            errors++;
            $display("FAIL send_timeout accepted=%0d required=1", a);
        end
    endtask

    task automatic drain(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 1000) begin
            step();
            k++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL drain_timeout results=%0d required=%0d", got_q.size(), n);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #7;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        got_q.delete();
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; x = '0; y = '0; z = '0;
        rst_n = 1'b0;
        #7;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        if (DATA_OUT !== '0)    begin errors++; $display("FAIL rst_data got=%0d exp=0", DATA_OUT); end
        if (sat !== 1'b0)       begin errors++; $display("FAIL rst_sat got=%b exp=0", sat); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        mode = 1'b0; x = 8'd10; y = 8'd20; z = 8'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", out_valid); end
        step();
        checks += 3;
        if (out_valid !== 1'b1)   begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        if (DATA_OUT !== 16'd205) begin errors++; $display("FAIL single_data got=%0d exp=205", DATA_OUT); end
        if (sat !== 1'b0)         begin errors++; $display("FAIL single_sat got=%b exp=0", sat); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_late got=%b exp=0", out_valid); end
    endtask

    task automatic test_frame();
        logic [IS-1:0] fx [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
        logic [IS-1:0] fy [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
        for (int c = 0; c <= 6; c++) begin
            if (c < 4) begin
                mode = 1'b1; x = fx[c]; y = fy[c]; z = 8'hFF; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            checks++;
            if (c + 1 == 5) begin
                if (out_valid !== 1'b1 || DATA_OUT !== 16'd100 || sat !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_result valid=%b data=%0d sat=%b exp valid=1 data=100 sat=0",
                             out_valid, DATA_OUT, sat);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL frame_spurious cycle=%0d got=%b exp=0", c + 1, out_valid);
            end
        end
    endtask

    task automatic test_saturate();
        got_q.delete();
        repeat (4) send(1'b1, 8'd255, 8'd255, 8'd0);
        repeat (4) send(1'b1, 8'd1, 8'd1, 8'd0);
        drain(2);
        checks += 2;
        if (got_q.size() < 2 || got_q[0] !== {1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL sat_frame got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : 17'h0, {1'b1, 16'hFFFF});
        end
        if (got_q.size() < 2 || got_q[1] !== {1'b0, 16'd4}) begin
            errors++;
            $display("FAIL sat_next_frame got=%h exp=%h", (got_q.size() > 1) ? got_q[1] : 17'h0, {1'b0, 16'd4});
        end
    endtask

    task automatic test_stall();
        logic [IS-1:0] sx [5], sy [5], sz [5];
        longint v;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            sx[i] = IS'($urandom); sy[i] = IS'($urandom); sz[i] = IS'($urandom);
            v = longint'(sx[i]) * longint'(sy[i]) + longint'(sz[i]);
            exp_q.push_back((v > 65535) ? {1'b1, 16'hFFFF} : {1'b0, v[15:0]});
        end
        fork
            begin
                for (int i = 0; i < 5; i++) send(1'b0, sx[i], sy[i], sz[i]);
            end
            begin
                logic [OS-1:0] held;
                int k;
                k = 0;
                while (out_valid !== 1'b1 && k < 50) begin step(); k++; end
                out_ready = 1'b0;
                held = DATA_OUT;
                repeat (3) begin
                    @(negedge clk);
                    checks += 3;
                    if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
                    if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", out_valid); end
                    if (DATA_OUT !== held)  begin errors++; $display("FAIL stall_frozen got=%0d exp=%0d", DATA_OUT, held); end
                    step();
                end
                out_ready = 1'b1;
            end
        join
        drain(5);
        repeat (5) step();
        checks++;
        if (got_q.size() != 5) begin errors++; $display("FAIL stall_count got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mode_change();
        got_q.delete();
        repeat (2) send(1'b1, 8'd2, 8'd3, 8'd0);
        send(1'b0, 8'd1, 8'd1, 8'd1);
        repeat (4) send(1'b1, 8'd1, 8'd1, 8'd0);
        drain(2);
        repeat (6) step();
        checks += 3;
        if (got_q.size() != 2) begin errors++; $display("FAIL modechg_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() < 1 || got_q[0] !== {1'b0, 16'd2}) begin
            errors++; $display("FAIL modechg_mode0 got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : 17'h0, {1'b0, 16'd2});
        end
        if (got_q.size() < 2 || got_q[1] !== {1'b0, 16'd4}) begin
            errors++; $display("FAIL modechg_frame got=%h exp=%h", (got_q.size() > 1) ? got_q[1] : 17'h0, {1'b0, 16'd4});
        end
    endtask

    task automatic test_reset_midframe();
        repeat (2) send(1'b1, 8'd3, 8'd3, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        if (DATA_OUT !== '0)    begin errors++; $display("FAIL midrst_data got=%0d exp=0", DATA_OUT); end
        if (sat !== 1'b0)       begin errors++; $display("FAIL midrst_sat got=%b exp=0", sat); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        got_q.delete();
        repeat (4) send(1'b1, 8'd1, 8'd1, 8'd0);
        drain(1);
        repeat (6) step();
        checks += 2;
        if (got_q.size() != 1) begin errors++; $display("FAIL midrst_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() < 1 || got_q[0] !== {1'b0, 16'd4}) begin
            errors++; $display("FAIL midrst_frame got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : 17'h0, {1'b0, 16'd4});
        end
    endtask

    // Reference: products grouped into frames of AL, frames restart on mode change.
    task automatic test_random();
        localparam int N = 160;
        logic          bm [N];
        logic [IS-1:0] bx [N], by [N], bz [N];
        longint acc, v;
        int     cnt;
        logic   last, done;
        apply_reset();
        exp_q.delete();
        last = 1'b0;
        for (int i = 0; i < N; i++) begin
            bm[i] = ($urandom_range(0, 9) == 0) ? ~last : last;
            last  = bm[i];
            bx[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : IS'($urandom);
            by[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : IS'($urandom);
            bz[i] = IS'($urandom);
        end
        acc = 0; cnt = 0; last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bm[i] != last) begin acc = 0; cnt = 0; end
            last = bm[i];
            if (!bm[i]) begin
                v = longint'(bx[i]) * longint'(by[i]) + longint'(bz[i]);
                exp_q.push_back((v > 65535) ? {1'b1, 16'hFFFF} : {1'b0, v[15:0]});
            end else begin
                acc += longint'(bx[i]) * longint'(by[i]);
                cnt++;
                if (cnt == AL) begin
                    exp_q.push_back((acc > 65535) ? {1'b1, 16'hFFFF} : {1'b0, acc[15:0]});
                    acc = 0; cnt = 0;
                end
            end
        end
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < N; i++) send(bm[i], bx[i], by[i], bz[i]);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        drain(exp_q.size());
        repeat (6) step();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_result idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_saturate();
        test_stall();
        test_mode_change();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_pipe.md
MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 Parameter input_size, default 8: operand width in bits, x/y/z; legal range 2..32.
REQ-002 Parameter output_size, default 16: result width in bits; legal range input_size..64.
REQ-003 Parameter acc_len, default 4: products per frame in accumulate mode; legal range 2..256.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  x/y/z/mode carry a beat.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 x, y  input  input_size each  unsigned multiplicands.
REQ-009 z  input  input_size  unsigned addend, mode 0 only.
REQ-010 mode  input  1  0 = x*y+z per beat; 1 = accumulate acc_len products.
REQ-011 out_valid  output  1  DATA_OUT/sat hold a result.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 DATA_OUT  output  output_size  registered unsigned result.
REQ-014 sat  output  1  DATA_OUT was clipped; qualified by out_valid.

Function
REQ-015 Beat accepted when in_valid && in_ready; result transferred when out_valid && out_ready.
REQ-016 stall = out_valid && !out_ready; in_ready = !stall, combinational, no dependence on in_valid.
REQ-017 During stall: both pipeline stages, accumulator and beat counter hold; DATA_OUT, sat and out_valid stay stable.
REQ-018 Stage 1: on acceptance, register p = x*y (2*input_size bits, unsigned), z and mode with a stage-1 valid bit; bubble otherwise.
REQ-019 Stage 2, mode 0: full-width s = p + z; DATA_OUT = s, or 2^output_size-1 with sat=1 if s exceeds it; out_valid=1.
REQ-020 Mode 0 latency: result appears on DATA_OUT exactly 2 cycles after the acceptance edge when no stall; throughput one beat per cycle.
REQ-021 Accumulator width 2*input_size + clog2(acc_len) + 1; never wraps internally.
REQ-022 Stage 2, mode 1: count = number of products already in acc; z ignored.
REQ-023 Mode 1, count < acc_len-1: acc += p, count += 1, no output beat (out_valid drops to 0 unless stall holds an earlier result).
REQ-024 Mode 1, count = acc_len-1: result = acc + p, saturated as in REQ-019; out_valid=1; acc and count cleared the same edge.
REQ-025 Mode 1 latency: frame result 2 cycles after acceptance of its acc_len-th beat.
REQ-026 Mode change: a stage-2 beat whose mode differs from the previous stage-2 beat's mode discards any partial acc/count first; a mode-1 beat then starts a new frame with count 0.
REQ-027 Stage-2 bubble (no stage-1 valid, no stall): acc and count hold, out_valid=0 after a transferred result.
REQ-028 Simultaneous transfer and new stage-2 result in the same cycle: old result leaves, new result loads, out_valid stays 1.
REQ-029 out_ready while out_valid=0 has no effect.
REQ-030 No cross-beat combinational path from in_valid/x/y/z/mode to any output.

Reset
REQ-031 rst_n low, asynchronously: out_valid=0, DATA_OUT=0, sat=0, both stage valids=0, acc=0, count=0; in_ready=1 while rst_n low.
REQ-032 Reset mid-frame or mid-stall discards all in-flight beats and partial accumulation; first accepted beat after rst_n rises processes normally.
REQ-033 Reset deassertion synchronous to clk in the integration; the block adds no synchronizer.

Verification (defaults 8/16/4)
REQ-034 Mode 0, x=10 y=20 z=5 accepted at cycle 0, out_ready=1 -> DATA_OUT=205, sat=0, out_valid=1 at cycle 2 only.
REQ-035 Mode 1, beats (1,2),(3,4),(5,6),(7,8) back-to-back -> single out_valid, DATA_OUT=100, sat=0, 2 cycles after 4th beat; none earlier.
REQ-036 Mode 1, four beats x=y=255 -> DATA_OUT=65535, sat=1; next frame (1,1)x4 -> 4, sat=0.
REQ-037 Mode 0 stream of 5 beats, out_ready=0 for 3 cycles after first result -> in_ready=0 same cycles, DATA_OUT frozen, all 5 results delivered in order, none lost or duplicated.
REQ-038 Mode 1, two beats (2,3) then mode 0 beat x=1 y=1 z=1 -> DATA_OUT=2; following mode 1 frame (1,1)x4 -> 4 (partial 12 discarded).
REQ-039 rst_n pulsed low after 2 mode-1 beats (3,3) -> outputs 0 immediately; then (1,1)x4 -> 4.
